mod_pass_check: RTL and testbench
=================================

# mod_pass_check

Password entry and attempt-counting stage for the music player's lock function; sits directly upstream of the buzzer module. Collects 4-digit keypad entries and compares them against a parameterised password, asserting `unlocked` on a match. After `MAX_TRIES` consecutive failures it holds `alarm` high for `ALARM_SEC` seconds. `alarm` drives the buzzer module's `ena` input.

## Interface

- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `PASS`, 16'h1234: password as 4 BCD digits; the most significant nibble is entered first.
- `MAX_TRIES`, 3: number of consecutive failures that triggers the alarm (range 1..3).
- `ALARM_SEC`, 10: alarm duration in seconds.
- `clk`  in  1  system clock. One clock domain; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `key_valid`  in  1  one-cycle strobe that qualifies `key_code`.
- `key_code`  in  4  key value: 0–9 are digits, 4'hE is CLEAR/LOCK, 4'hF is ENTER, 4'hA–4'hD are ignored.
- `unlocked`  out  1  high while in the UNLOCKED state.
- `alarm`  out  1  high while in the ALARM state; connects to the buzzer's `ena`.
- `fail_pulse`  out  1  one-cycle pulse on each rejected ENTER.
- `tries`  out  2  current count of consecutive failures.
- `dig_cnt`  out  3  number of digits buffered so far (0..4), for display.

## Operation

- Internal state: a 16-bit buffer `buf`, `dig_cnt`, `tries`, the FSM state, and a 32-bit alarm counter `acnt`.
- FSM states are LOCKED, UNLOCKED and ALARM. The reset state is LOCKED.
- Keys are only acted on in cycles where `key_valid` = 1. Unlisted keys cause no state change.
- LOCKED state:
  - Digit with `dig_cnt` < 4: `buf <= {buf[11:0], key_code}` and `dig_cnt` increments.
  - Digit with `dig_cnt` = 4: ignored; `buf` and `dig_cnt` are unchanged.
  - CLEAR: `buf` and `dig_cnt` go to 0. `tries` is unchanged.
  - ENTER with `dig_cnt` = 4 and `buf` = `PASS`: go to UNLOCKED and set `tries` to 0.
  - ENTER in any other case (including `dig_cnt` < 4, or an empty buffer): this is a failure.
    - `fail_pulse` fires and `tries` increments.
    - If the new `tries` equals `MAX_TRIES`, go to ALARM and load `acnt` with 0.
  - Every ENTER, pass or fail, clears `buf` and `dig_cnt`.
- UNLOCKED state:
  - CLEAR goes to LOCKED; the buffer is already empty.
  - All other keys are ignored.
- ALARM state:
  - All keys are ignored.
  - `acnt` increments every cycle.
  - When `acnt` = `ALARM_SEC*CLK_FREQ - 1`, go to LOCKED and set `tries` to 0.
- `tries` never exceeds `MAX_TRIES`. It resets only in three cases: on reset, on a successful ENTER, or at the end of the alarm.
- `acnt` is 32 bits wide. `ALARM_SEC*CLK_FREQ` must fit in 32 bits; the product is computed as a 32-bit localparam.

## Timing

- All outputs are registered.
- Reset values: `unlocked` = 0, `alarm` = 0, `fail_pulse` = 0, `tries` = 0, `dig_cnt` = 0, `buf` = 0, `acnt` = 0.
- A key sampled at edge N is reflected in every output after edge N. Latency is one cycle from the strobe to the output.
- `fail_pulse` is high for exactly the one cycle after the failing ENTER edge.
  - On the third failure, `fail_pulse` and `alarm` rise in the same cycle.
- `alarm` is high for exactly `ALARM_SEC*CLK_FREQ` cycles, then low, with LOCKED in the following cycle.
- A key strobe arriving in the same cycle that the alarm expires is ignored.
- `rst` has priority over every other event. Reset applied mid-entry or mid-alarm returns the block to LOCKED and clears all outputs on the next edge.
- Back-to-back `key_valid` strobes on consecutive cycles are each processed. No minimum gap is required.

## Test plan

All scenarios use `CLK_FREQ` = 100, `ALARM_SEC` = 2, `PASS` = 16'h1234, `MAX_TRIES` = 3.

- Correct entry: keys 1, 2, 3, 4, ENTER → `unlocked` = 1 one cycle after ENTER; `tries` = 0; `fail_pulse` never pulses. Then CLEAR → `unlocked` = 0.
- Wrong and short entries:
  - 1, 2, 3, 5, ENTER → `fail_pulse` high for 1 cycle, `tries` = 1, `unlocked` = 0.
  - Then 1, 2, ENTER → `tries` = 2, `dig_cnt` = 0.
- Overflow and clear:
  - 1, 2, 3, 4, 9, ENTER → unlocks, because the 5th digit is ignored.
  - 1, 2, CLEAR, 3, 4, ENTER → fails, and `tries` increments.
- Alarm:
  - Three wrong ENTERs → `alarm` rises in the same cycle as the 3rd `fail_pulse` and stays high for exactly 200 cycles.
  - Keys pressed during the alarm have no effect.
  - After the alarm, `tries` = 0, `alarm` = 0, and 1, 2, 3, 4, ENTER unlocks.
- Reset mid-operation:
  - `rst` asserted 50 cycles into the alarm → next cycle `alarm` = 0 and `tries` = 0.
  - `rst` asserted after 2 buffered digits → `dig_cnt` = 0.
- Failure-count reset: two failures, then a correct entry, then CLEAR, then one failure → `tries` = 1 and no alarm.

Source files
------------

// File: rtl/mod_pass_check.sv
// -----------------------------------------------------------------------------
// mod_pass_check
//
// Password entry and attempt counting for the music player's lock function.
// This block collects 4-digit keypad entries and compares each one against
// the PASS parameter. A match asserts `unlocked`. After MAX_TRIES consecutive
// failed entries, `alarm` stays high for ALARM_SEC seconds. `alarm` drives
// the buzzer's `ena` input.
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous, active-high reset
//   key_valid  in   1  one-cycle strobe qualifying key_code
//   key_code   in   4  0-9 digit, E = CLEAR/LOCK, F = ENTER, A-D ignored
//   unlocked   out  1  high while UNLOCKED
//   alarm      out  1  high while ALARM (buzzer enable)
//   fail_pulse out  1  one-cycle pulse per rejected ENTER
//   tries      out  2  consecutive failure count
//   dig_cnt    out  3  digits buffered so far (0..4)
//
// Every output is a flop. A key sampled at edge N is visible right after
// edge N.
// -----------------------------------------------------------------------------
module mod_pass_check #(
   parameter int unsigned CLK_FREQ  = 50_000_000,
   parameter logic [15:0] PASS      = 16'h1234,
   parameter int unsigned MAX_TRIES = 3,
   parameter int unsigned ALARM_SEC = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic       unlocked,
   output logic       alarm,
   output logic       fail_pulse,
   output logic [1:0] tries,
   output logic [2:0] dig_cnt
);

   // ALARM_SEC*CLK_FREQ must fit in 32 bits.
   localparam logic [31:0] ALARM_CYC = 32'(ALARM_SEC * CLK_FREQ);
   localparam logic [31:0] ACNT_LAST = ALARM_CYC - 32'd1;
   localparam logic [1:0]  TRIES_MAX = 2'(MAX_TRIES);

   localparam logic [3:0]  KEY_CLEAR = 4'hE;
   localparam logic [3:0]  KEY_ENTER = 4'hF;

   typedef enum logic [1:0] {
      S_LOCKED   = 2'd0,
      S_UNLOCKED = 2'd1,
      S_ALARM    = 2'd2
   } state_t;

   state_t      state_q, state_nxt;
   logic [15:0] pin_q, pin_nxt;
   logic [2:0]  dig_nxt;
   logic [1:0]  tries_nxt, tries_inc;
   logic [31:0] acnt_q, acnt_nxt;
   logic        fail_nxt;
   logic        is_digit;

   assign is_digit  = (key_code <= 4'd9);
   assign tries_inc = tries + 2'd1;

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned. That rule prevents inferred latches.
   always_comb begin
      state_nxt = state_q;
      pin_nxt   = pin_q;
      dig_nxt   = dig_cnt;
      tries_nxt = tries;
      acnt_nxt  = acnt_q;
      fail_nxt  = 1'b0;

      case (state_q)
         S_LOCKED: begin
            if (key_valid) begin
               if (is_digit) begin
                  // A fifth and later digit is dropped; the buffer holds the first four.
                  if (dig_cnt < 3'd4) begin
                     pin_nxt = {pin_q[11:0], key_code};
                     dig_nxt = dig_cnt + 3'd1;
                  end
               end else if (key_code == KEY_CLEAR) begin
                  pin_nxt = '0;
                  dig_nxt = '0;
               end else if (key_code == KEY_ENTER) begin
                  pin_nxt = '0;
                  dig_nxt = '0;
                  if ((dig_cnt == 3'd4) && (pin_q == PASS)) begin
                     state_nxt = S_UNLOCKED;
                     tries_nxt = '0;
                  end else begin
                     fail_nxt  = 1'b1;
                     tries_nxt = tries_inc;
                     if (tries_inc == TRIES_MAX) begin
                        state_nxt = S_ALARM;
                        acnt_nxt  = '0;
                     end
                  end
               end
            end
         end

         S_UNLOCKED: begin
            if (key_valid && (key_code == KEY_CLEAR)) begin
               state_nxt = S_LOCKED;
            end
         end

         S_ALARM: begin
            // Keys are ignored for the whole alarm, and on the expiry cycle too.
            if (acnt_q == ACNT_LAST) begin
               state_nxt = S_LOCKED;
               tries_nxt = '0;
               acnt_nxt  = '0;
            end else begin
               acnt_nxt  = acnt_q + 32'd1;
            end
         end

         default: begin
            state_nxt = S_LOCKED;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only. Every flop
   // then samples the values from before the edge, whatever order the
   // statements are in.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_LOCKED;
         pin_q      <= '0;
         dig_cnt    <= '0;
         tries      <= '0;
         acnt_q     <= '0;
         fail_pulse <= 1'b0;
         unlocked   <= 1'b0;
         alarm      <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         pin_q      <= pin_nxt;
         dig_cnt    <= dig_nxt;
         tries      <= tries_nxt;
         acnt_q     <= acnt_nxt;
         fail_pulse <= fail_nxt;
         // unlocked and alarm are decoded from the next state, so they
         // change on the same edge as the state.
         unlocked   <= (state_nxt == S_UNLOCKED);
         alarm      <= (state_nxt == S_ALARM);
      end
   end

endmodule

// File: tb/tb_mod_pass_check.sv
// -----------------------------------------------------------------------------
// tb_mod_pass_check
//
// Bench for mod_pass_check with CLK_FREQ = 100 and ALARM_SEC = 2, so the
// alarm lasts 200 cycles. A table of single-cycle vectors covers entry,
// failures, overflow and clear. Hand-written sequences cover the alarm
// window, keys during and at expiry, and reset mid-alarm / mid-entry.
// Outputs are packed as {unlocked, alarm, fail_pulse, tries[1:0], dig_cnt[2:0]}.
// -----------------------------------------------------------------------------
module tb_mod_pass_check;

   localparam int unsigned ALARM_LEN = 200;
   localparam logic [3:0]  K_CLR = 4'hE;
   localparam logic [3:0]  K_ENT = 4'hF;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_valid;
   logic [3:0] key_code;
   logic       unlocked;
   logic       alarm;
   logic       fail_pulse;
   logic [1:0] tries;
   logic [2:0] dig_cnt;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   mod_pass_check #(
      .CLK_FREQ (100),
      .PASS     (16'h1234),
      .MAX_TRIES(3),
      .ALARM_SEC(2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_code  (key_code),
      .unlocked  (unlocked),
      .alarm     (alarm),
      .fail_pulse(fail_pulse),
      .tries     (tries),
      .dig_cnt   (dig_cnt)
   );

   typedef struct {
      logic       rst;
      logic       kv;
      logic [3:0] kc;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [7:0] pk(input logic u, input logic a, input logic f,
                                     input logic [1:0] t, input logic [2:0] d);
      return {u, a, f, t, d};
   endfunction

   function automatic logic [7:0] obs();
      return {unlocked, alarm, fail_pulse, tries, dig_cnt};
   endfunction

   task automatic add(input logic r, input logic kv, input logic [3:0] kc,
                      input logic u, input logic a, input logic f,
                      input logic [1:0] t, input logic [2:0] d);
      vec_t v;
      v.rst = r;
      v.kv  = kv;
      v.kc  = kc;
      v.exp = pk(u, a, f, t, d);
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, then sample 1 time unit after the edge.
   task automatic step(input logic r, input logic kv, input logic [3:0] kc);
      rst       = r;
      key_valid = kv;
      key_code  = kc;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      key_valid = 1'b0;
   endtask

   initial begin
      int  cnt;
      bit  done;

      rst       = 1'b1;
      key_valid = 1'b0;
      key_code  = 4'h0;

      //   rst kv key     u  a  f  t  d
      add(1, 0, 4'h0,   0, 0, 0, 0, 0);  // reset state
      // correct entry, then lock
      add(0, 1, 4'h1,   0, 0, 0, 0, 1);
      add(0, 1, 4'h2,   0, 0, 0, 0, 2);
      add(0, 1, 4'h3,   0, 0, 0, 0, 3);
      add(0, 1, 4'h4,   0, 0, 0, 0, 4);
      add(0, 1, K_ENT,  1, 0, 0, 0, 0);
      add(0, 0, 4'h0,   1, 0, 0, 0, 0);
      add(0, 1, 4'h5,   1, 0, 0, 0, 0);  // digit ignored while unlocked
      add(0, 1, K_CLR,  0, 0, 0, 0, 0);
      // wrong digit
      add(0, 1, 4'h1,   0, 0, 0, 0, 1);
      add(0, 1, 4'h2,   0, 0, 0, 0, 2);
      add(0, 1, 4'h3,   0, 0, 0, 0, 3);
      add(0, 1, 4'h5,   0, 0, 0, 0, 4);
      add(0, 1, K_ENT,  0, 0, 1, 1, 0);
      add(0, 0, 4'h0,   0, 0, 0, 1, 0);
      // short entry
      add(0, 1, 4'h1,   0, 0, 0, 1, 1);
      add(0, 1, 4'h2,   0, 0, 0, 1, 2);
      add(0, 1, K_ENT,  0, 0, 1, 2, 0);
      add(0, 0, 4'h0,   0, 0, 0, 2, 0);
      // fifth digit ignored, unlock resets tries
      add(0, 1, 4'h1,   0, 0, 0, 2, 1);
      add(0, 1, 4'h2,   0, 0, 0, 2, 2);
      add(0, 1, 4'h3,   0, 0, 0, 2, 3);
      add(0, 1, 4'h4,   0, 0, 0, 2, 4);
      add(0, 1, 4'h9,   0, 0, 0, 2, 4);
      add(0, 1, K_ENT,  1, 0, 0, 0, 0);
      add(0, 1, K_CLR,  0, 0, 0, 0, 0);
      // clear mid-entry, then a failing ENTER
      add(0, 1, 4'h1,   0, 0, 0, 0, 1);
      add(0, 1, 4'h2,   0, 0, 0, 0, 2);
      add(0, 1, K_CLR,  0, 0, 0, 0, 0);
      add(0, 1, 4'h3,   0, 0, 0, 0, 1);
      add(0, 1, 4'h4,   0, 0, 0, 0, 2);
      add(0, 1, K_ENT,  0, 0, 1, 1, 0);
      add(0, 1, 4'hA,   0, 0, 0, 1, 0);  // ignored key
      // two failures, correct entry, clear, one failure -> tries 1
      add(0, 1, K_ENT,  0, 0, 1, 2, 0);  // empty buffer ENTER fails
      add(0, 0, 4'h0,   0, 0, 0, 2, 0);
      add(0, 1, 4'h1,   0, 0, 0, 2, 1);
      add(0, 1, 4'h2,   0, 0, 0, 2, 2);
      add(0, 1, 4'h3,   0, 0, 0, 2, 3);
      add(0, 1, 4'h4,   0, 0, 0, 2, 4);
      add(0, 1, K_ENT,  1, 0, 0, 0, 0);
      add(0, 1, K_CLR,  0, 0, 0, 0, 0);
      add(0, 1, K_ENT,  0, 0, 1, 1, 0);
      add(0, 0, 4'h0,   0, 0, 0, 1, 0);

      repeat (2) @(posedge clk);
      #1;
      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].kv, vecs[i].kc);
         check($sformatf("vec%0d", i), 32'(obs()), 32'(vecs[i].exp));
      end

      // ---------------- alarm window, keys during and at expiry ------------
      step(1, 0, 4'h0);
      check("alarm rst", 32'(obs()), 32'(pk(0, 0, 0, 0, 0)));
      step(0, 1, K_ENT);
      check("alarm f1", 32'(obs()), 32'(pk(0, 0, 1, 1, 0)));
      step(0, 1, K_ENT);
      check("alarm f2", 32'(obs()), 32'(pk(0, 0, 1, 2, 0)));
      step(0, 1, K_ENT);
      check("alarm f3", 32'(obs()), 32'(pk(0, 1, 1, 3, 0)));
      cnt  = 1;
      done = 1'b0;
      key_valid = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         key_code = (i % 2 == 0) ? 4'h1 : K_ENT;
         @(posedge clk);
         #1;
         if (!alarm) begin
            done = 1'b1;
            break;
         end
         cnt++;
         check("alarm hold", 32'({unlocked, fail_pulse, tries, dig_cnt}),
               32'({1'b0, 1'b0, 2'd3, 3'd0}));
      end
      key_valid = 1'b0;
      check("alarm ended", 32'(done), 32'd1);
      check("alarm length", 32'(cnt), 32'(ALARM_LEN));
      check("alarm exit", 32'(obs()), 32'(pk(0, 0, 0, 0, 0)));
      step(0, 1, 4'h1);
      step(0, 1, 4'h2);
      step(0, 1, 4'h3);
      step(0, 1, 4'h4);
      check("post alarm d4", 32'(obs()), 32'(pk(0, 0, 0, 0, 4)));
      step(0, 1, K_ENT);
      check("post alarm unlock", 32'(obs()), 32'(pk(1, 0, 0, 0, 0)));
      step(0, 1, K_CLR);
      check("post alarm lock", 32'(obs()), 32'(pk(0, 0, 0, 0, 0)));

      // ---------------- reset 50 cycles into the alarm ---------------------
      step(0, 1, K_ENT);
      step(0, 1, K_ENT);
      step(0, 1, K_ENT);
      check("alarm2 f3", 32'(obs()), 32'(pk(0, 1, 1, 3, 0)));
      repeat (49) step(0, 0, 4'h0);
      check("alarm2 mid", 32'(obs()), 32'(pk(0, 1, 0, 3, 0)));
      step(1, 1, 4'h1);
      check("alarm2 rst", 32'(obs()), 32'(pk(0, 0, 0, 0, 0)));
      step(0, 0, 4'h0);
      check("alarm2 after", 32'(obs()), 32'(pk(0, 0, 0, 0, 0)));

      // ---------------- reset with two digits buffered ---------------------
      step(0, 1, 4'h1);
      step(0, 1, 4'h2);
      check("entry d2", 32'(obs()), 32'(pk(0, 0, 0, 0, 2)));
      step(1, 1, 4'h3);
      check("entry rst", 32'(obs()), 32'(pk(0, 0, 0, 0, 0)));
      step(0, 1, 4'h3);
      check("entry after rst", 32'(obs()), 32'(pk(0, 0, 0, 0, 1)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   // Hard time limit: the stimulus above uses well under 1000 cycles.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got no summary, expected finish");
      $fatal(1, "timeout");
   end

endmodule
